// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the byte-serial adder: op encodings, FSM states, slice width.
// Build option: WIDE_ADD_SLT_EN enables the set-less-than result path.
package wide_add_seq_pkg;

    localparam int SLICE_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SLT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Subtract and slt both run as a + ~b + 1; add and the spare code 11 run as a + b.
    function automatic logic op_is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/wide_add_seq_cla8.sv
// 8-bit carry-lookahead slice: every carry is a flat sum of generate/propagate products.
// Also reports group propagate/generate for cascading.
module cla8
    import wide_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] g_i,
    input  logic [SLICE_W-1:0] p_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] c_o,
    output logic               pg_o,
    output logic               gg_o
);

    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_carry
        logic gen_bit;
        logic prop_bit;

        // gen_bit is the carry out of bit gi assuming cin=0; prop_bit says cin reaches it.
        always_comb begin
            logic acc;
            logic chain;
            acc = g_i[gi];
            for (int j = 0; j < gi; j++) begin
                chain = 1'b1;
                for (int k = j + 1; k <= gi; k++) begin
                    chain = chain & p_i[k];
                end
                acc = acc | (g_i[j] & chain);
            end
            gen_bit  = acc;
            prop_bit = &p_i[gi:0];
        end

        assign c_o[gi] = gen_bit | (prop_bit & cin_i);
    end

    assign pg_o = g_carry[SLICE_W-1].prop_bit;
    assign gg_o = g_carry[SLICE_W-1].gen_bit;

endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial wide add/sub/slt: one cla8 slice reused LSB-first over WIDTH/8 cycles.
// Build option: WIDE_ADD_SLT_EN (undefined: op 10 returns the raw difference).
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
`ifdef WIDE_ADD_SLT_EN
    logic               slt_q, slt_d;
`endif

    logic [SLICE_W-1:0] a_bytes [NSLICE];
    logic [SLICE_W-1:0] b_bytes [NSLICE];
    logic [SLICE_W-1:0] a_byte, b_byte;
    logic [SLICE_W-1:0] slice_g, slice_p, slice_c, sum_byte;
    logic               grp_p, grp_g, slice_cout;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_byte_mux
        assign a_bytes[gi] = a_q[gi*SLICE_W +: SLICE_W];
        assign b_bytes[gi] = b_q[gi*SLICE_W +: SLICE_W];
    end

    assign a_byte  = a_bytes[idx_q];
    assign b_byte  = b_bytes[idx_q];
    assign slice_g = a_byte & b_byte;
    assign slice_p = a_byte ^ b_byte;

    cla8 u_cla8 (
        .g_i   (slice_g),
        .p_i   (slice_p),
        .cin_i (carry_q),
        .c_o   (slice_c),
        .pg_o  (grp_p),
        .gg_o  (grp_g)
    );

    assign sum_byte   = slice_p ^ {slice_c[SLICE_W-2:0], carry_q};
    assign slice_cout = grp_g | (grp_p & carry_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
`ifdef WIDE_ADD_SLT_EN
        slt_d    = slt_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op_is_sub(op) ? ~b : b;
                    carry_d = op_is_sub(op);
                    idx_d   = '0;
`ifdef WIDE_ADD_SLT_EN
                    slt_d   = (op == OP_SLT);
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[i*SLICE_W +: SLICE_W] = sum_byte;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_c[SLICE_W-1];
                    ovf_d   = slice_c[SLICE_W-2] ^ slice_c[SLICE_W-1];
`ifdef WIDE_ADD_SLT_EN
                    // Signed less-than is the difference sign corrected by overflow.
                    if (slt_q) begin
                        result_d = {{(WIDTH-1){1'b0}},
                                    sum_byte[SLICE_W-1] ^ slice_c[SLICE_W-2] ^ slice_c[SLICE_W-1]};
                    end
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef WIDE_ADD_SLT_EN
            slt_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
`ifdef WIDE_ADD_SLT_EN
            slt_q    <= slt_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WIDTH=32): directed table, corner sequences, random vs model.
// Honours WIDE_ADD_SLT_EN for the expected slt results.
module tb_wide_add_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    wide_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [1:0]   vop;
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
    } vec_t;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on a 33-bit sum; slt from a signed compare.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [1:0] mop,
                         output logic [W-1:0] r, output logic c, output logic o);
        logic         is_sub;
        logic [W-1:0] beff;
        logic [W:0]   s;
        is_sub = (mop == 2'b01) || (mop == 2'b10);
        beff   = is_sub ? ~mb : mb;
        s      = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, is_sub};
        r      = s[W-1:0];
        c      = s[W];
        o      = (ma[W-1] == beff[W-1]) && (r[W-1] != ma[W-1]);
`ifdef WIDE_ADD_SLT_EN
        if (mop == 2'b10) r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
`endif
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    // One full transaction with out_ready held high; inputs scrambled right after accept.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top,
                          input logic [W-1:0] er, input logic ec, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = 1'b1;
        check({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        wait_valid(lat);
        // out_valid is first seen in the 5th cycle after the accept edge (4 slice edges later)
        check({nm, ".latency"}, lat, 32'd5);
        check({nm, ".result"}, result, er);
        check({nm, ".cout"}, {31'd0, cout}, {31'd0, ec});
        check({nm, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
        $display("%s: op=%0d a=%h b=%h -> result=%h cout=%b ovf=%b lat=%0d",
                 nm, top, ta, tb, result, cout, ovf, lat);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] ra, rb, er;
        logic [1:0]   rop;
        logic         ec, eo;
        int           lat;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 2'b01, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 1'b1, 1'b1};
`ifdef WIDE_ADD_SLT_EN
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 32'h0000_0001, 1'b1, 1'b0};
`else
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 32'hFFFF_FFFE, 1'b1, 1'b0};
`endif
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 2'b10, 32'h0000_0001, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_0010, 32'h0000_0020, 2'b11, 32'h0000_0030, 1'b0, 1'b0};
        vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 2'b00, 32'h0100_0100, 1'b0, 1'b0};

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; a = '0; b = '0;
        #3 rst_n = 1'b0;
        #2;
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.result", result, 32'd0);
        check("reset.cout", {31'd0, cout}, 32'd0);
        check("reset.ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, vecs[i].er, vecs[i].ec, vecs[i].eo,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 6 cycles while pulsing in_valid with other operands.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; op = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(lat);
        check("bp.latency", lat, 32'd5);
        for (int i = 0; i < 6; i++) begin
            check("bp.out_valid", {31'd0, out_valid}, 32'd1);
            check("bp.in_ready", {31'd0, in_ready}, 32'd0);
            check("bp.result", result, 32'h2345_6789);
            in_valid = (i % 2 == 0);
            a = $urandom; b = $urandom; op = 2'b01;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release.in_ready", {31'd0, in_ready}, 32'd1);
        check("bp.release.out_valid", {31'd0, out_valid}, 32'd0);
        $display("bp: held 6 cycles result=%h then released", 32'h2345_6789);
        run_op(32'h0000_0001, 32'h0000_0002, 2'b00, 32'h0000_0003, 1'b0, 1'b0, "bp.next");

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; op = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.out_valid", {31'd0, out_valid}, 32'd0);
        check("abort.in_ready", {31'd0, in_ready}, 32'd1);
        check("abort.result", result, 32'd0);
        check("abort.cout", {31'd0, cout}, 32'd0);
        $display("abort: reset in RUN -> in_ready=%b out_valid=%b", in_ready, out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000_0003, 32'h0000_0004, 2'b00, 32'h0000_0007, 1'b0, 1'b0, "abort.next");

        for (int i = 0; i < 40; i++) begin
            ra  = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) ? 1'b1 : 1'b0, {(W-1){$urandom_range(0, 1) == 1}}} : W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            rop = 2'($urandom_range(0, 3));
            model(ra, rb, rop, er, ec, eo);
            run_op(ra, rb, rop, er, ec, eo, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
